// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3
// size/sign encodings, byte-enable base patterns and the timeout counter
// width helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // funct3[1:0] encodes the access size, funct3[2] selects zero-extension.
  localparam logic [1:0] F3_SIZE_B   = 2'b00;
  localparam logic [1:0] F3_SIZE_H   = 2'b01;
  localparam logic [1:0] F3_SIZE_W   = 2'b10;
  localparam int         F3_UNS_BIT  = 2;

  // Byte-enable patterns before shifting into the addressed lane.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Width of a counter that must be able to hold the value cyc.
  function automatic int cnt_width(input int cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master)
// and the memory (slave).
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              BUS_REQ;
  logic              BUS_WE;
  logic [ADDR_W-1:0] BUS_ADDR;
  logic [ADDR_W-1:0] BUS_WDATA;
  logic [3:0]        BUS_BE;
  logic              BUS_ACK;
  logic [ADDR_W-1:0] BUS_RDATA;

  modport master (
    output BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA, BUS_BE,
    input  BUS_ACK, BUS_RDATA
  );

  modport slave (
    input  BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA, BUS_BE,
    output BUS_ACK, BUS_RDATA
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: legality and alignment checks, byte enables,
// store-data lane replication and load-data extraction with extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_legal_load,
  output logic        o_legal_store,
  output logic        o_misalign,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [1:0]  w_size;
  logic        w_uns;
  logic [31:0] w_shifted;

  assign w_size    = i_funct3[1:0];
  assign w_uns     = i_funct3[F3_UNS_BIT];
  // Move the addressed lane down to bit 0 so extraction is lane-agnostic.
  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  // Size decode: legality, alignment, enables, store replication, load extension.
  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    o_legal_load  = 1'b0;
    o_legal_store = 1'b0;
    o_misalign    = 1'b0;
    o_be          = BE_WORD;
    o_wdata       = i_wdata;
    o_rdata       = w_shifted;
    case (w_size)
      F3_SIZE_B: begin
        o_legal_load  = 1'b1;
        o_legal_store = ~w_uns;
        o_be          = BE_BYTE << i_addr_lo;
        o_wdata       = {4{i_wdata[7:0]}};
        o_rdata       = w_uns ? {24'd0, w_shifted[7:0]}
                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      F3_SIZE_H: begin
        o_legal_load  = 1'b1;
        o_legal_store = ~w_uns;
        o_misalign    = i_addr_lo[0];
        o_be          = BE_HALF << {i_addr_lo[1], 1'b0};
        o_wdata       = {2{i_wdata[15:0]}};
        o_rdata       = w_uns ? {16'd0, w_shifted[15:0]}
                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      F3_SIZE_W: begin
        // LWU does not exist in RV32I.
        o_legal_load  = ~w_uns;
        o_legal_store = ~w_uns;
        o_misalign    = (i_addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: launches one req/ack bus transaction per memory
// instruction, stalls the core until it completes, and returns the aligned,
// extended load result. Misaligned requests are suppressed; illegal requests
// and bus timeouts raise a one-cycle BUS_ERR.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MEMR,
  input  logic              MEMW,
  input  logic [2:0]        FUNCT3,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [ADDR_W-1:0] WDATA,
  output logic              STALL,
  output logic [ADDR_W-1:0] MEM_DATA_R,
  output logic              LSU_DONE,
  output logic              MISALIGN,
  output logic              BUS_ERR,
  load_store_unit_if.master bus
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:2]  r_addr;
  logic [1:0]         r_lane;
  logic [2:0]         r_funct3;
  logic               r_we;
  logic [3:0]         r_be;
  logic [ADDR_W-1:0]  r_wdata;
  logic [ADDR_W-1:0]  r_mem_data;

  logic               w_idle;
  logic               w_in_req;
  logic               w_legal;
  logic               w_launch;
  logic               w_bad_req;
  logic               w_mis;
  logic               w_cnt_last;
  logic [2:0]         w_f3_sel;
  logic [1:0]         w_lane_sel;
  logic               w_legal_load;
  logic               w_legal_store;
  logic               w_misalign;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_rep;
  logic [31:0]        w_rdata_ext;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_in_req = (r_state == ST_REQ);

  // In IDLE the lane logic looks at the live request; afterwards it decodes
  // the latched access so the load is extracted with the launch-time lane.
  assign w_f3_sel   = w_idle ? FUNCT3     : r_funct3;
  assign w_lane_sel = w_idle ? ADDR[1:0]  : r_lane;

  lsu_lane_align u_align (
    .i_funct3      (w_f3_sel),
    .i_addr_lo     (w_lane_sel),
    .i_wdata       (WDATA),
    .i_rdata       (bus.BUS_RDATA),
    .o_legal_load  (w_legal_load),
    .o_legal_store (w_legal_store),
    .o_misalign    (w_misalign),
    .o_be          (w_be),
    .o_wdata       (w_wdata_rep),
    .o_rdata       (w_rdata_ext)
  );

  // A request is legal only if exactly one of MEMR/MEMW is set with a supported funct3.
  assign w_legal    = (MEMR & ~MEMW & w_legal_load) | (MEMW & ~MEMR & w_legal_store);
  assign w_launch   = w_idle & w_legal & ~w_misalign;
  assign w_mis      = w_idle & w_legal &  w_misalign;
  assign w_bad_req  = w_idle & (MEMR | MEMW) & ~w_legal;
  assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; DONE and ERR always return to IDLE without relaunching.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_bad_req)     w_state_nxt = ST_ERR;
        else if (w_launch) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bus.BUS_ACK)     w_state_nxt = ST_DONE;
        else if (w_cnt_last) w_state_nxt = ST_ERR;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Launch latches, timeout counter and load-result capture.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_lane     <= '0;
      r_funct3   <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_mem_data <= '0;
    end else if (w_launch) begin
      r_cnt      <= '0;
      r_addr     <= ADDR[ADDR_W-1:2];
      r_lane     <= ADDR[1:0];
      r_funct3   <= FUNCT3;
      r_we       <= MEMW;
      r_be       <= w_be;
      r_wdata    <= w_wdata_rep;
    end else if (w_bad_req) begin
      r_mem_data <= '0;
    end else if (w_in_req) begin
      if (bus.BUS_ACK) begin
        if (!r_we) r_mem_data <= w_rdata_ext;
      end else if (w_cnt_last) begin
        r_mem_data <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Core-facing outputs are gated by reset so a held MEMR cannot stall the core in reset.
  assign STALL      = RST & (w_launch | w_bad_req | w_in_req);
  assign MISALIGN   = RST & w_mis;
  assign LSU_DONE   = (r_state == ST_DONE);
  assign BUS_ERR    = (r_state == ST_ERR);
  assign MEM_DATA_R = w_mis ? '0 : r_mem_data;

  assign bus.BUS_REQ   = w_in_req;
  assign bus.BUS_WE    = w_in_req & r_we;
  assign bus.BUS_ADDR  = {r_addr, 2'b00};
  assign bus.BUS_BE    = r_be;
  assign bus.BUS_WDATA = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of accesses with hand-computed
// expectations, plus sequences for timeout and mid-request reset.
module tb_load_store_unit;

  typedef enum int { K_OK, K_MIS, K_ILL } kind_e;

  typedef struct {
    string       name;
    logic        memr;
    logic        memw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_cyc;
    kind_e       kind;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_bwdata;
    logic [31:0] exp_data;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        MEMR = 1'b0;
  logic        MEMW = 1'b0;
  logic [2:0]  FUNCT3 = 3'b000;
  logic [31:0] ADDR = '0;
  logic [31:0] WDATA = '0;
  logic        STALL;
  logic [31:0] MEM_DATA_R;
  logic        LSU_DONE;
  logic        MISALIGN;
  logic        BUS_ERR;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .MEMR       (MEMR),
    .MEMW       (MEMW),
    .FUNCT3     (FUNCT3),
    .ADDR       (ADDR),
    .WDATA      (WDATA),
    .STALL      (STALL),
    .MEM_DATA_R (MEM_DATA_R),
    .LSU_DONE   (LSU_DONE),
    .MISALIGN   (MISALIGN),
    .BUS_ERR    (BUS_ERR),
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive one access from IDLE and follow it back to IDLE.
  task automatic run_access(input vec_t v);
    int stall_cyc;
    MEMR = v.memr; MEMW = v.memw; FUNCT3 = v.f3; ADDR = v.addr; WDATA = v.wdata;
    bus.BUS_ACK = 1'b0; bus.BUS_RDATA = v.rdata;
    #1;
    case (v.kind)
      K_MIS: begin
        check({v.name, "_misalign"}, 32'(MISALIGN), 32'd1);
        check({v.name, "_stall"},    32'(STALL),    32'd0);
        check({v.name, "_data0"},    MEM_DATA_R,    32'd0);
        tick();
        check({v.name, "_noreq"},    32'(bus.BUS_REQ), 32'd0);
        check({v.name, "_nowe"},     32'(bus.BUS_WE),  32'd0);
        MEMR = 1'b0; MEMW = 1'b0;
      end
      K_ILL: begin
        check({v.name, "_stall"}, 32'(STALL), 32'd1);
        tick();
        MEMR = 1'b0; MEMW = 1'b0;
        #1;
        check({v.name, "_buserr"}, 32'(BUS_ERR),     32'd1);
        check({v.name, "_stall0"}, 32'(STALL),       32'd0);
        check({v.name, "_data0"},  MEM_DATA_R,       32'd0);
        check({v.name, "_noreq"},  32'(bus.BUS_REQ), 32'd0);
        tick();
        check({v.name, "_errpulse"}, 32'(BUS_ERR), 32'd0);
      end
      default: begin
        stall_cyc = STALL ? 1 : 0;
        tick();
        check({v.name, "_req"},   32'(bus.BUS_REQ), 32'd1);
        check({v.name, "_baddr"}, bus.BUS_ADDR,     v.exp_baddr);
        check({v.name, "_be"},    32'(bus.BUS_BE),  32'(v.exp_be));
        check({v.name, "_we"},    32'(bus.BUS_WE),  32'(v.memw));
        if (v.memw) check({v.name, "_bwdata"}, bus.BUS_WDATA, v.exp_bwdata);
        for (int w = 0; w < v.wait_cyc; w++) begin
          stall_cyc += STALL ? 1 : 0;
          tick();
        end
        bus.BUS_ACK = 1'b1;
        #1;
        stall_cyc += STALL ? 1 : 0;
        check({v.name, "_req_held"}, 32'(bus.BUS_REQ), 32'd1);
        tick();
        bus.BUS_ACK = 1'b0; MEMR = 1'b0; MEMW = 1'b0;
        #1;
        check({v.name, "_done"},      32'(LSU_DONE),    32'd1);
        check({v.name, "_stall0"},    32'(STALL),       32'd0);
        check({v.name, "_reqdrop"},   32'(bus.BUS_REQ), 32'd0);
        check({v.name, "_stall_cyc"}, 32'(stall_cyc),   32'(v.wait_cyc + 2));
        if (v.memr) check({v.name, "_data"}, MEM_DATA_R, v.exp_data);
        tick();
        check({v.name, "_donepulse"}, 32'(LSU_DONE), 32'd0);
      end
    endcase
  endtask

  vec_t vecs[$];

  initial begin
    int  req_cyc;
    bit  seen_err;
    vec_t v;

    bus.BUS_ACK = 1'b0;
    bus.BUS_RDATA = '0;

    //        name      r     w     f3      addr          wdata         rdata         wait kind   baddr         be       bwdata        data
    vecs.push_back('{"lw",   1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, K_OK,  32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF});
    vecs.push_back('{"lb",   1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8011_2233, 0, K_OK,  32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80});
    vecs.push_back('{"lbu",  1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8011_2233, 0, K_OK,  32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080});
    vecs.push_back('{"sh",   1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        0, K_OK,  32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0});
    vecs.push_back('{"lw_mis",1'b1,1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         0, K_MIS, 32'h0,         4'b0000, 32'h0,        32'h0});
    vecs.push_back('{"sw_mis",1'b0,1'b1, 3'b010, 32'h0000_0102, 32'h5555_AAAA, 32'h0,        0, K_MIS, 32'h0,         4'b0000, 32'h0,        32'h0});
    vecs.push_back('{"lh",   1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 0, K_OK,  32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_8001});
    vecs.push_back('{"lhu",  1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0,        32'h1234_F00D, 2, K_OK,  32'h0000_0000, 4'b0011, 32'h0,        32'h0000_F00D});
    vecs.push_back('{"sb",   1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,        0, K_OK,  32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 32'h0});
    vecs.push_back('{"lh_mis",1'b1,1'b0, 3'b001, 32'h0000_0003, 32'h0,        32'h0,         0, K_MIS, 32'h0,         4'b0000, 32'h0,        32'h0});
    vecs.push_back('{"ill_f3",1'b1,1'b0, 3'b011, 32'h0000_0010, 32'h0,        32'h0,         0, K_ILL, 32'h0,         4'b0000, 32'h0,        32'h0});
    vecs.push_back('{"ill_rw",1'b1,1'b1, 3'b010, 32'h0000_0010, 32'h0,        32'h0,         0, K_ILL, 32'h0,         4'b0000, 32'h0,        32'h0});
    vecs.push_back('{"sw",   1'b0, 1'b1, 3'b010, 32'h0000_040C, 32'hCAFE_F00D, 32'h0,        2, K_OK,  32'h0000_040C, 4'b1111, 32'hCAFE_F00D, 32'h0});
    vecs.push_back('{"sbu_ill",1'b0,1'b1,3'b100, 32'h0000_0010, 32'h0,        32'h0,         0, K_ILL, 32'h0,         4'b0000, 32'h0,        32'h0});

    // Reset state with a request already pending on the core side.
    MEMR = 1'b1; FUNCT3 = 3'b010;
    #12;
    check("rst_stall",   32'(STALL),       32'd0);
    check("rst_req",     32'(bus.BUS_REQ), 32'd0);
    check("rst_done",    32'(LSU_DONE),    32'd0);
    check("rst_mis",     32'(MISALIGN),    32'd0);
    check("rst_err",     32'(BUS_ERR),     32'd0);
    check("rst_data",    MEM_DATA_R,       32'd0);
    MEMR = 1'b0;
    tick();
    RST = 1'b1;
    tick();

    foreach (vecs[i]) run_access(vecs[i]);

    // Timeout: BUS_REQ must stay high exactly 16 cycles before BUS_ERR.
    MEMR = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h0000_0500; bus.BUS_ACK = 1'b0;
    req_cyc = 0;
    seen_err = 1'b0;
    for (int c = 0; c < 40 && !seen_err; c++) begin
      tick();
      if (BUS_ERR) seen_err = 1'b1;
      else if (bus.BUS_REQ) req_cyc++;
    end
    MEMR = 1'b0;
    #1;
    check("tmo_seen",   32'(seen_err),    32'd1);
    check("tmo_reqcyc", 32'(req_cyc),     32'd16);
    check("tmo_stall",  32'(STALL),       32'd0);
    check("tmo_data",   MEM_DATA_R,       32'd0);
    check("tmo_reqlow", 32'(bus.BUS_REQ), 32'd0);
    tick();
    check("tmo_pulse",  32'(BUS_ERR),     32'd0);
    v = '{"tmo_next", 1'b1, 1'b0, 3'b010, 32'h0000_0504, 32'h0, 32'h0BAD_F00D, 0, K_OK,
          32'h0000_0504, 4'b1111, 32'h0, 32'h0BAD_F00D};
    run_access(v);

    // Asynchronous reset in the middle of REQ.
    MEMR = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h0000_0600; bus.BUS_ACK = 1'b0;
    tick();
    tick();
    check("arst_pre_req", 32'(bus.BUS_REQ), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check("arst_req",   32'(bus.BUS_REQ), 32'd0);
    check("arst_stall", 32'(STALL),       32'd0);
    MEMR = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    check("arst_noresume", 32'(bus.BUS_REQ), 32'd0);
    v = '{"arst_lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_FF00, 0, K_OK,
          32'h0000_0000, 4'b0010, 32'h0, 32'h0000_00FF};
    run_access(v);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
